// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshakes and NZCV flags.
// Optional iterative shift-add multiplier enabled by defining ALU_MC_MUL_EN.
module alu_mc #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);
    localparam int SHW = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd1;
`ifdef ALU_MC_MUL_EN
    localparam logic [1:0] BUSY = 2'd2;
    localparam logic [SHW-1:0] LAST = SHW'(N - 1);
`endif

    logic [1:0]   state_q, state_d;
    logic [N-1:0] result_q, result_d;
    logic         zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;

`ifdef ALU_MC_MUL_EN
    logic [N-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   acc_step;
`endif

    logic [N:0]   add_w, sub_w;
    logic [N-1:0] alu_res;
    logic         alu_c, alu_v, accept, is_mul;

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

`ifdef ALU_MC_MUL_EN
    assign is_mul = (ALUControl == 4'b1000);
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle datapath; only sampled into registers on accept.
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        alu_res = '1;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a | b;
            4'b0010: begin
                alu_res = add_w[N-1:0];
                alu_c   = add_w[N];
                alu_v   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            4'b0110: begin
                alu_res = sub_w[N-1:0];
                alu_c   = ~sub_w[N];
                alu_v   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
            end
            4'b0111: alu_res = b;
            4'b0011: alu_res = a << b[SHW-1:0];
            4'b0100: alu_res = a >> b[SHW-1:0];
            default: alu_res = '1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
`ifdef ALU_MC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
        if (accept) begin
            if (is_mul) begin
`ifdef ALU_MC_MUL_EN
                state_d  = BUSY;
                mcand_d  = a;
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
`endif
            end else begin
                state_d  = DONE;
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                neg_d    = alu_res[N-1];
                carry_d  = alu_c;
                ovf_d    = alu_v;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
`ifdef ALU_MC_MUL_EN
        // Fixed N iterations, no early exit, so latency is data-independent.
        if (state_q == BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == LAST) begin
                state_d  = DONE;
                result_d = acc_step;
                zero_d   = (acc_step == '0);
                neg_d    = acc_step[N-1];
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
`ifdef ALU_MC_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end
endmodule
